// File: rtl/dw_pkg.sv
// Shared definitions for the depthwise chain controller.
//   - default widths and chain length
//   - controller state encoding
//   - bit positions inside the sticky err vector
package dw_pkg;

    localparam int DW_DATA_WIDTH     = 8;
    localparam int DW_OUT_DATA_WIDTH = 32;
    localparam int DW_TAPS           = 3;
    localparam int DW_LEN_W          = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } dw_state_t;

    // err[ERR_ACT_GAP]: activation missing during STREAM
    // err[ERR_BAD_LEN]: cfg_start with a row shorter than the chain
    localparam int ERR_ACT_GAP = 0;
    localparam int ERR_BAD_LEN = 1;
    localparam int ERR_W       = 2;

endpackage

// File: rtl/dw_chain_ctrl_if.sv
// Bundle of every non-clock/reset signal of dw_chain_ctrl.
//   cfg_*           row configuration (start pulse, length, weight reuse)
//   w_*             weight stream, tap 0 first
//   s_act_*         activation stream
//   wgt_load/_data  per-cell weight load strobes and shared weight bus
//   act             activation into cell 0
//   chain_macc      accumulator output of the last cell
//   m_valid/m_data  finished results, no backpressure
//   busy/done/err   status
// Modports: slave = controller side, master = environment side.
interface dw_chain_ctrl_if
    import dw_pkg::*;
#(
    parameter int DATA_WIDTH     = DW_DATA_WIDTH,
    parameter int OUT_DATA_WIDTH = DW_OUT_DATA_WIDTH,
    parameter int TAPS           = DW_TAPS,
    parameter int LEN_W          = DW_LEN_W
);

    logic                      cfg_start;
    logic [LEN_W-1:0]          cfg_len;
    logic                      cfg_reuse_wgt;

    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;

    logic                      s_act_valid;
    logic                      s_act_ready;
    logic [DATA_WIDTH-1:0]     s_act_data;

    logic [TAPS-1:0]           wgt_load;
    logic [DATA_WIDTH-1:0]     wgt_data;
    logic [DATA_WIDTH-1:0]     act;
    logic [OUT_DATA_WIDTH-1:0] chain_macc;

    logic                      m_valid;
    logic [OUT_DATA_WIDTH-1:0] m_data;

    logic                      busy;
    logic                      done;
    logic [ERR_W-1:0]          err;

    modport slave (
        input  cfg_start, cfg_len, cfg_reuse_wgt,
        input  w_valid, w_data,
        input  s_act_valid, s_act_data,
        input  chain_macc,
        output w_ready, s_act_ready,
        output wgt_load, wgt_data, act,
        output m_valid, m_data,
        output busy, done, err
    );

    modport master (
        output cfg_start, cfg_len, cfg_reuse_wgt,
        output w_valid, w_data,
        output s_act_valid, s_act_data,
        output chain_macc,
        input  w_ready, s_act_ready,
        input  wgt_load, wgt_data, act,
        input  m_valid, m_data,
        input  busy, done, err
    );

endinterface

// File: rtl/dw_tag_delay.sv
// Fixed-depth 1-bit shift register used to line the "result is real" tag
// up with the chain's accumulator output.
//   clk    clock
//   reset  asynchronous active-high reset, clears every stage
//   din    tag entering stage 0
//   dout   tag leaving the last stage (DEPTH edges after it entered)
module dw_tag_delay #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/dw_chain_ctrl.sv
// Initiator-side controller for a 1-D chain of TAPS depthwise systolic cells.
// Loads one weight per cell, streams one activation per cycle into cell 0 and
// collects valid-mode convolution results from the last cell's macc output.
//   clk    clock
//   reset  asynchronous active-high reset
//   bus    dw_chain_ctrl_if.slave: cfg, weight stream, activation stream,
//          cell-side weight/act drive, chain_macc, results and status
//
// state  | meaning
// IDLE   | waiting for cfg_start; rejects rows shorter than the chain
// LOAD   | accepting TAPS weights, one load strobe per handshake
// STREAM | exactly N cycles of activations into cell 0, gaps become zeros
// DRAIN  | flushing the tag pipe so the last results come out, then done
module dw_chain_ctrl
    import dw_pkg::*;
#(
    parameter int DATA_WIDTH     = DW_DATA_WIDTH,
    parameter int OUT_DATA_WIDTH = DW_OUT_DATA_WIDTH,
    parameter int TAPS           = DW_TAPS,
    parameter int LEN_W          = DW_LEN_W
) (
    input  logic           clk,
    input  logic           reset,
    dw_chain_ctrl_if.slave bus
);

    localparam int K_W = $clog2(TAPS);
    localparam int D_W = $clog2(TAPS + 1);

    localparam logic [K_W-1:0]   K_LAST    = K_W'(TAPS - 1);
    localparam logic [D_W-1:0]   D_LOAD    = D_W'(TAPS);
    localparam logic [LEN_W-1:0] LEN_MIN   = LEN_W'(TAPS);
    localparam logic [LEN_W-1:0] TAG_FIRST = LEN_W'(TAPS - 1);
    localparam logic [TAPS-1:0]  ONE_HOT0  = TAPS'(1);

    dw_state_t state, state_nxt;

    logic [K_W-1:0]            k_idx;
    logic [LEN_W-1:0]          j_idx;
    logic [LEN_W-1:0]          n_len;
    logic [D_W-1:0]            drain_cnt;

    logic                      start_ok;
    logic                      start_bad;
    logic                      in_load;
    logic                      in_stream;
    logic                      in_drain;
    logic                      w_ready_c;
    logic                      s_act_ready_c;
    logic                      busy_c;

    logic                      w_fire;
    logic                      k_last;
    logic                      j_last;
    logic                      drain_end;
    logic                      tag_in;
    logic                      tag_out;

    logic [TAPS-1:0]           wgt_load_q;
    logic [DATA_WIDTH-1:0]     wgt_data_q;
    logic [DATA_WIDTH-1:0]     act_q;
    logic                      m_valid_q;
    logic [OUT_DATA_WIDTH-1:0] m_data_q;
    logic                      done_q;
    logic [ERR_W-1:0]          err_q;

    assign w_fire    = in_load && bus.w_valid;
    assign k_last    = (k_idx == K_LAST);
    assign j_last    = (j_idx == n_len - LEN_W'(1));
    assign drain_end = in_drain && (drain_cnt == '0);

    // Only rows positions with a full window behind them are real results;
    // the first TAPS-1 chain outputs still hold the previous row or zeros.
    assign tag_in = in_stream && (j_idx >= TAG_FIRST);

    // ---------------------------------------------------------------- FSM

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = bus.cfg_reuse_wgt ? ST_STREAM : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_fire && k_last) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (j_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start_ok      = 1'b0;
        start_bad     = 1'b0;
        in_load       = 1'b0;
        in_stream     = 1'b0;
        in_drain      = 1'b0;
        w_ready_c     = 1'b0;
        s_act_ready_c = 1'b0;
        busy_c        = 1'b1;
        case (state)
            ST_IDLE: begin
                busy_c    = 1'b0;
                start_ok  = bus.cfg_start && (bus.cfg_len >= LEN_MIN);
                start_bad = bus.cfg_start && (bus.cfg_len <  LEN_MIN);
            end
            ST_LOAD: begin
                in_load   = 1'b1;
                w_ready_c = 1'b1;
            end
            ST_STREAM: begin
                in_stream     = 1'b1;
                s_act_ready_c = 1'b1;
            end
            ST_DRAIN: begin
                in_drain = 1'b1;
            end
            default: busy_c = 1'b0;
        endcase
    end

    // ----------------------------------------------------------- counters

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_idx     <= '0;
            j_idx     <= '0;
            n_len     <= '0;
            drain_cnt <= '0;
        end else begin
            if (start_ok) begin
                k_idx <= '0;
                j_idx <= '0;
                n_len <= bus.cfg_len;
            end else begin
                if (w_fire) begin
                    k_idx <= k_idx + K_W'(1);
                end
                if (in_stream) begin
                    j_idx <= j_idx + LEN_W'(1);
                end
            end
            // Down-counter covering the TAPS+1 edges the tag pipe needs to
            // empty after the last activation.
            if (in_stream && j_last) begin
                drain_cnt <= D_LOAD;
            end else if (in_drain && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - D_W'(1);
            end
        end
    end

    // ----------------------------------------------------------- datapath

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wgt_load_q <= '0;
            wgt_data_q <= '0;
            act_q      <= '0;
        end else begin
            wgt_load_q <= '0;
            if (w_fire) begin
                wgt_load_q <= ONE_HOT0 << k_idx;
                wgt_data_q <= bus.w_data;
            end
            // The cells cannot stall, so a missing activation still uses up
            // its slot as a zero.
            act_q <= (in_stream && bus.s_act_valid) ? bus.s_act_data : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= drain_end;
            if (start_ok) begin
                err_q <= '0;
            end else begin
                if (start_bad) begin
                    err_q[ERR_BAD_LEN] <= 1'b1;
                end
                if (in_stream && !bus.s_act_valid) begin
                    err_q[ERR_ACT_GAP] <= 1'b1;
                end
            end
        end
    end

    dw_tag_delay #(
        .DEPTH (TAPS + 1)
    ) u_tag_delay (
        .clk   (clk),
        .reset (reset),
        .din   (tag_in),
        .dout  (tag_out)
    );

    // chain_macc is passed through untouched; m_data keeps its last result
    // between valid cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= tag_out;
            if (tag_out) begin
                m_data_q <= bus.chain_macc;
            end
        end
    end

    assign bus.w_ready     = w_ready_c;
    assign bus.s_act_ready = s_act_ready_c;
    assign bus.busy        = busy_c;
    assign bus.wgt_load    = wgt_load_q;
    assign bus.wgt_data    = wgt_data_q;
    assign bus.act         = act_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_data      = m_data_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_dw_chain_ctrl.sv
// Directed bench for dw_chain_ctrl with a behavioural TAPS-cell chain and a
// result scoreboard.
module tb_dw_chain_ctrl;
    import dw_pkg::*;

    localparam int TAPS = 3;
    localparam int DW   = 8;
    localparam int ODW  = 32;
    localparam int LW   = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int busy_cnt, wr_cnt, sr_cnt, wl_cnt, done_cnt, mv_cnt, first_mv;

    int exp_q[$];
    int row_w[TAPS];
    int cur_w[TAPS];
    int row_a[$];

    always #5 clk = ~clk;

    dw_chain_ctrl_if #(
        .DATA_WIDTH     (DW),
        .OUT_DATA_WIDTH (ODW),
        .TAPS           (TAPS),
        .LEN_W          (LW)
    ) bus ();

    dw_chain_ctrl #(
        .DATA_WIDTH     (DW),
        .OUT_DATA_WIDTH (ODW),
        .TAPS           (TAPS),
        .LEN_W          (LW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Cell chain: an act registered at edge e shows up in chain_macc
    // after edge e+TAPS. Cells keep their weights across controller reset.
    logic signed [DW-1:0]  cw   [TAPS];
    logic signed [DW-1:0]  hist [TAPS];
    logic signed [ODW-1:0] dly  [TAPS-1];
    int sum0;

    always_comb begin
        sum0 = 0;
        for (int k = 0; k < TAPS; k++) begin
            sum0 = sum0 + int'(cw[k]) * int'(hist[k]);
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < TAPS; k++) begin
            if (bus.wgt_load[k]) cw[k] <= bus.wgt_data;
        end
        hist[0] <= bus.act;
        for (int k = 1; k < TAPS; k++) hist[k] <= hist[k-1];
        dly[0] <= sum0;
        for (int i = 1; i < TAPS - 1; i++) dly[i] <= dly[i-1];
    end

    assign bus.chain_macc = dly[TAPS-2];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        busy_cnt = 0; wr_cnt = 0; sr_cnt = 0; wl_cnt = 0;
        done_cnt = 0; mv_cnt = 0; first_mv = -1;
    endtask

    // One clock; observe outputs on the falling edge and score results.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.busy)            busy_cnt++;
        if (bus.w_ready)         wr_cnt++;
        if (bus.s_act_ready)     sr_cnt++;
        if (bus.wgt_load != '0)  wl_cnt++;
        if (bus.done)            done_cnt++;
        if (bus.m_valid) begin
            mv_cnt++;
            if (first_mv < 0) first_mv = cyc;
            if (exp_q.size() == 0) chk("m_valid_unexpected", exp_q.size(), 1);
            else chk("m_data", $signed(bus.m_data), exp_q.pop_front());
        end
    endtask

    // Runs one row from row_w/row_a. gap_j drops s_act_valid at that index;
    // stop_after >= 0 returns mid-STREAM after that many activations.
    task automatic run_row(input bit reuse, input int gap_j, input int stop_after,
                           input string nm);
        int n;
        int y;
        int hs_cyc;
        bit v;
        int eff[$];
        n = row_a.size();
        hs_cyc = 0;
        clr_stats();
        bus.cfg_start = 1'b1;
        bus.cfg_len = LW'(n);
        bus.cfg_reuse_wgt = reuse;
        tick();
        bus.cfg_start = 1'b0;
        bus.cfg_reuse_wgt = 1'b0;
        if (!reuse) begin
            for (int k = 0; k < TAPS; k++) begin
                bus.w_valid = 1'b1;
                bus.w_data = DW'(row_w[k]);
                tick();
                chk({nm, "_wgt_load"}, bus.wgt_load, 1 << k);
                chk({nm, "_wgt_data"}, $signed(bus.wgt_data), row_w[k]);
                cur_w[k] = row_w[k];
            end
            bus.w_valid = 1'b0;
            bus.w_data = '0;
        end
        for (int j = 0; j < n; j++) begin
            if (j == stop_after) return;
            v = (j != gap_j);
            bus.s_act_valid = v;
            bus.s_act_data = DW'(row_a[j]);
            // a short-row start while busy must be ignored
            bus.cfg_start = (j == 1);
            bus.cfg_len = (j == 1) ? LW'(1) : LW'(n);
            eff.push_back(v ? row_a[j] : 0);
            if (j >= TAPS - 1) begin
                y = 0;
                for (int k = 0; k < TAPS; k++) y = y + cur_w[k] * eff[j-k];
                exp_q.push_back(y);
            end
            tick();
            chk({nm, "_act"}, $signed(bus.act), v ? row_a[j] : 0);
            if (j == TAPS - 1) hs_cyc = cyc;
        end
        bus.s_act_valid = 1'b0;
        bus.s_act_data = '0;
        bus.cfg_start = 1'b0;
        bus.cfg_len = '0;
        for (int t = 0; t < 4 * TAPS + 8 && done_cnt == 0; t++) tick();
        tick();
        chk({nm, "_done_pulses"},    done_cnt, 1);
        chk({nm, "_busy_after"},     bus.busy, 0);
        chk({nm, "_busy_cycles"},    busy_cnt, (reuse ? 0 : TAPS) + n + TAPS + 1);
        chk({nm, "_stream_cycles"},  sr_cnt, n);
        chk({nm, "_wgt_load_cycles"}, wl_cnt, reuse ? 0 : TAPS);
        chk({nm, "_w_ready_cycles"}, wr_cnt, reuse ? 0 : TAPS);
        chk({nm, "_result_count"},   mv_cnt, n - TAPS + 1);
        chk({nm, "_queue_left"},     exp_q.size(), 0);
        chk({nm, "_latency"},        first_mv - hs_cyc, TAPS + 1);
        chk({nm, "_err"},            bus.err, (gap_j >= 0 && gap_j < n) ? 1 : 0);
    endtask

    initial begin
        bus.cfg_start = 1'b0;
        bus.cfg_len = '0;
        bus.cfg_reuse_wgt = 1'b0;
        bus.w_valid = 1'b0;
        bus.w_data = '0;
        bus.s_act_valid = 1'b0;
        bus.s_act_data = '0;
        clr_stats();

        repeat (2) @(negedge clk);
        chk("rst_busy",        bus.busy, 0);
        chk("rst_err",         bus.err, 0);
        chk("rst_m_valid",     bus.m_valid, 0);
        chk("rst_w_ready",     bus.w_ready, 0);
        chk("rst_s_act_ready", bus.s_act_ready, 0);
        chk("rst_wgt_load",    bus.wgt_load, 0);
        chk("rst_done",        bus.done, 0);
        reset = 1'b0;
        tick();

        row_w = '{1, 2, 3};
        row_a = '{1, 2, 3, 4, 5};
        run_row(1'b0, -1, -1, "row1");

        row_a = '{1, 1, 1};
        run_row(1'b1, -1, -1, "reuse");

        row_w = '{-1, 0, 1};
        row_a = '{100, -128, 127, 5};
        run_row(1'b0, -1, -1, "signed");

        row_a = '{1, 2, 3, 4, 5, 6};
        run_row(1'b1, 3, -1, "gap");

        // row shorter than the chain is rejected; err[0] stays sticky
        clr_stats();
        bus.cfg_start = 1'b1;
        bus.cfg_len = LW'(2);
        tick();
        bus.cfg_start = 1'b0;
        bus.cfg_len = '0;
        chk("badlen_err", bus.err, 3);
        repeat (6) tick();
        chk("badlen_busy_cycles", busy_cnt, 0);
        chk("badlen_wgt_load",    wl_cnt, 0);
        chk("badlen_w_ready",     wr_cnt, 0);
        chk("badlen_m_valid",     mv_cnt, 0);

        // reset in the middle of STREAM, between clock edges
        row_w = '{1, 2, 3};
        row_a = '{1, 2, 3, 4, 5};
        run_row(1'b0, 1, 3, "abort");
        bus.s_act_valid = 1'b0;
        bus.s_act_data = '0;
        bus.cfg_start = 1'b0;
        bus.cfg_len = '0;
        chk("abort_err_before",  bus.err, 1);
        chk("abort_busy_before", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_wgt_load",    bus.wgt_load, 0);
        chk("arst_wgt_data",    bus.wgt_data, 0);
        chk("arst_act",         bus.act, 0);
        chk("arst_m_valid",     bus.m_valid, 0);
        chk("arst_m_data",      bus.m_data, 0);
        chk("arst_done",        bus.done, 0);
        chk("arst_err",         bus.err, 0);
        chk("arst_busy",        bus.busy, 0);
        chk("arst_w_ready",     bus.w_ready, 0);
        chk("arst_s_act_ready", bus.s_act_ready, 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();

        run_row(1'b0, -1, -1, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dw_chain_ctrl.md
Name: dw_chain_ctrl

Overview:
- Initiator-side controller for a 1-D chain of TAPS depthwise systolic cells: loads one weight per cell, streams one activation per cycle into cell 0, and collects finished sums from the last cell's macc output.
- Per row: computes valid-mode 1-D convolution y(c) = sum_k w_k * a(c-k), k = 0..TAPS-1, and emits only fully-formed results (N-TAPS+1 per row of N).
- The cells have no stall, so the activation stream must be gap-free once a row starts; the controller flags violations.

Parameters:
- DATA_WIDTH, 8, activation/weight width, signed.
- OUT_DATA_WIDTH, 32, accumulator/result width, signed.
- TAPS, 3, number of cells in the chain (>=2).
- LEN_W, 10, width of the row-length field.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_start  in  1  pulse; starts a row when IDLE.
- cfg_len  in  LEN_W  row length N; sampled with cfg_start.
- cfg_reuse_wgt  in  1  sampled with cfg_start; 1 = skip LOAD.
- w_valid  in  1  weight stream valid.
- w_ready  out  1  weight stream ready.
- w_data  in  DATA_WIDTH  weight, tap 0 first.
- s_act_valid  in  1  activation valid.
- s_act_ready  out  1  activation ready.
- s_act_data  in  DATA_WIDTH  activation.
- wgt_load  out  TAPS  one-hot per-cell weight load strobe.
- wgt_data  out  DATA_WIDTH  shared weight bus to cells.
- act  out  DATA_WIDTH  activation into cell 0.
- chain_macc  in  OUT_DATA_WIDTH  macc output of last cell.
- m_valid  out  1  result valid, one cycle per result, no backpressure.
- m_data  out  OUT_DATA_WIDTH  result.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse at end of row.
- err  out  2  sticky: bit0 act gap in STREAM, bit1 bad cfg_len; cleared only by a new accepted cfg_start or reset.

Behaviour:
- Reset (async, any state, including mid-row):
  - State IDLE; counters zero; tag pipe cleared.
  - All outputs 0: wgt_load, wgt_data, act, m_valid, m_data, done, err, busy, w_ready, s_act_ready.
  - Cells are reset separately; the controller does not drive them.
- IDLE:
  - On cfg_start with cfg_len < TAPS: set err[1], stay IDLE.
  - Otherwise latch N and clear err.
  - Next state is STREAM if cfg_reuse_wgt=1, else LOAD.
  - cfg_start outside IDLE is ignored.
- LOAD:
  - w_ready=1; weight index k counts 0..TAPS-1.
  - On each w handshake, register wgt_data<=w_data and wgt_load<=onehot(k) for exactly one cycle.
  - wgt_load is 0 on every cycle without a handshake.
  - After handshake k=TAPS-1, go to STREAM; wgt_load returns to 0 on the following edge.
- STREAM:
  - s_act_ready=1; exactly N edges, one per cycle; index j counts 0..N-1.
  - If s_act_valid=1: act<=s_act_data.
  - If s_act_valid=0: act<=0, err[0] set, j still advances. The cycle is consumed; no stall.
  - Push tag into the delay line each edge: tag=1 iff j>=TAPS-1.
  - After j=N-1, go to DRAIN.
- DRAIN:
  - s_act_ready=0; act held at 0.
  - Stay until the tag pipe is empty (TAPS+1 edges), then pulse done for one cycle and return to IDLE.
- Timing:
  - An activation registered onto act at edge e reaches chain_macc after edge e+TAPS.
  - The tag delay line has depth TAPS+1.
  - At edge e+TAPS+1: m_data<=chain_macc, m_valid<=tag.
  - Latency: handshake edge to m_valid high = TAPS+1 edges.
  - m_data holds its last value when m_valid=0.
- Warm-up: the first TAPS-1 chain outputs of each row mix in the previous row or zeros and are never tagged valid.
- Arithmetic: the controller does no arithmetic on results; it passes chain_macc through unchanged. Width sizing of OUT_DATA_WIDTH is the integrator's responsibility.
- busy=1 in LOAD, STREAM and DRAIN.

Decomposition:
- Package dw_pkg holds:
  - the state encoding (IDLE, LOAD, STREAM, DRAIN);
  - the err bit index constants;
  - default DATA_WIDTH/OUT_DATA_WIDTH.
- One sub-module, dw_tag_delay: parameterized-depth 1-bit shift register with async reset, used for result valid alignment.

Test Plan:
- TAPS=3, weights 1,2,3, N=5, acts 1,2,3,4,5 gap-free -> wgt_load pulses 001,010,100 on consecutive handshakes; m_data 10,16,22 on three consecutive cycles; first m_valid 4 edges after act 3's handshake; done once; err=0.
- Weights -1,0,1, N=4, acts 100,-128,127,5 -> m_data -27, -133; signed correct.
- Second row with cfg_reuse_wgt=1, acts 1,1,1 -> no wgt_load pulse, w_ready stays 0, m_data 6.
- s_act_valid dropped for one cycle mid-row -> err[0]=1, row still finishes after exactly N STREAM cycles, done pulses.
- cfg_len=2 with TAPS=3 -> err[1]=1, busy stays 0, no wgt_load/m_valid.
- Reset asserted during STREAM, asynchronously between edges -> all outputs 0 immediately; next cfg_start runs a clean row matching scenario 1.
